// File: rtl/sha_ser_pkg.sv
// Shared types, default sizes and helpers for the word-serial SHA datapath blocks.
package sha_ser_pkg;

    localparam int unsigned WORD_W_DEF    = 32;
    localparam int unsigned NUM_WORDS_DEF = 16;

    typedef enum logic {
        IDLE,
        SHIFT
    } pts_state_t;

    // Reverse byte order of a 32-bit word (big-endian <-> little-endian).
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/pts_sr_16_ctrl_if.sv
// Block-load / word-serial output bus of the parallel-to-serial message register.
interface pts_sr_16_ctrl_if #(
    parameter int unsigned NUM_WORDS = 16,
    parameter int unsigned WORD_W    = 32
);
    localparam int unsigned IDX_W = $clog2(NUM_WORDS);

    logic                          load_valid;
    logic                          load_ready;
    logic [NUM_WORDS*WORD_W-1:0]   parallel_in;
    logic [WORD_W-1:0]             serial_out;
    logic                          out_valid;
    logic                          out_ready;
    logic                          out_last;
    logic [IDX_W-1:0]              word_idx;

    // Block producer and word consumer side.
    modport master (
        output load_valid,
        output parallel_in,
        output out_ready,
        input  load_ready,
        input  serial_out,
        input  out_valid,
        input  out_last,
        input  word_idx
    );

    // Serializer side.
    modport slave (
        input  load_valid,
        input  parallel_in,
        input  out_ready,
        output load_ready,
        output serial_out,
        output out_valid,
        output out_last,
        output word_idx
    );

endinterface

// File: rtl/pts_sr.sv
// Load/shift-enable parallel-to-serial register: top word is presented, shifts up with zero fill.
module pts_sr #(
    parameter int unsigned NUM_WORDS = 16,
    parameter int unsigned WORD_W    = 32
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        clr,
    input  logic                        load,
    input  logic                        shift,
    input  logic [NUM_WORDS*WORD_W-1:0] parallel_in,
    output logic [WORD_W-1:0]           top_word
);
    localparam int unsigned TOTAL_W = NUM_WORDS * WORD_W;

    logic [TOTAL_W-1:0] sr_q;

    // clr beats load beats shift.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sr_q <= '0;
        end else if (clr) begin
            sr_q <= '0;
        end else if (load) begin
            sr_q <= parallel_in;
        end else if (shift) begin
            sr_q <= {sr_q[TOTAL_W-WORD_W-1:0], WORD_W'(0)};
        end
    end

    assign top_word = sr_q[TOTAL_W-1 -: WORD_W];

endmodule

// File: rtl/pts_sr_16_ctrl.sv
// Serializes a NUM_WORDS x WORD_W block into words with valid/ready flow control, MS word first.
// Optional PTS_BYTE_SWAP_EN byte-reverses every emitted word for little-endian consumers.
module pts_sr_16_ctrl
    import sha_ser_pkg::*;
#(
    parameter int unsigned NUM_WORDS = NUM_WORDS_DEF,
    parameter int unsigned WORD_W    = WORD_W_DEF
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 clear,
    pts_sr_16_ctrl_if.slave      bus
);
    localparam int unsigned IDX_W = $clog2(NUM_WORDS);

    pts_state_t         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               sr_load, sr_shift, sr_clr;
    logic               take, at_last;
    logic [WORD_W-1:0]  top_word;

    assign take    = (state_q == SHIFT) && bus.out_ready;
    assign at_last = (idx_q == IDX_W'(NUM_WORDS - 1));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next state, word counter and shift-register controls.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        sr_load  = 1'b0;
        sr_shift = 1'b0;
        sr_clr   = 1'b0;
        if (clear) begin
            state_d = IDLE;
            idx_d   = '0;
            sr_clr  = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.load_valid) begin
                        state_d = SHIFT;
                        idx_d   = '0;
                        sr_load = 1'b1;
                    end
                end
                SHIFT: begin
                    if (take) begin
                        if (at_last) begin
                            idx_d = '0;
                            // A block waiting on the final handshake follows with no bubble.
                            if (bus.load_valid) begin
                                sr_load = 1'b1;
                            end else begin
                                state_d  = IDLE;
                                sr_shift = 1'b1;
                            end
                        end else begin
                            idx_d    = idx_q + IDX_W'(1);
                            sr_shift = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    pts_sr #(
        .NUM_WORDS (NUM_WORDS),
        .WORD_W    (WORD_W)
    ) u_sr (
        .clk         (clk),
        .n_rst       (n_rst),
        .clr         (sr_clr),
        .load        (sr_load),
        .shift       (sr_shift),
        .parallel_in (bus.parallel_in),
        .top_word    (top_word)
    );

    // The only combinational path: out_ready on the final word re-opens the load port.
    assign bus.load_ready = (state_q == IDLE) || (take && at_last);
    assign bus.out_valid  = (state_q == SHIFT);
    assign bus.out_last   = (state_q == SHIFT) && at_last;
    assign bus.word_idx   = idx_q;

`ifdef PTS_BYTE_SWAP_EN
    localparam int unsigned NUM_BYTES = WORD_W / 8;
    logic [WORD_W-1:0] swapped;

    // WORD_W is expected to be a whole number of bytes here.
    always_comb begin
        swapped = '0;
        for (int unsigned b = 0; b < NUM_BYTES; b++) begin
            swapped[b*8 +: 8] = top_word[(NUM_BYTES-1-b)*8 +: 8];
        end
    end

    assign bus.serial_out = swapped;
`else
    assign bus.serial_out = top_word;
`endif

endmodule

// File: tb/tb_pts_sr_16_ctrl.sv
// Directed self-checking bench for pts_sr_16_ctrl: reset, single block, stall, back-to-back, flush.
module tb_pts_sr_16_ctrl;
    import sha_ser_pkg::*;

    localparam int unsigned NW = 16;
    localparam int unsigned WW = 32;

    logic clk = 1'b0;
    logic n_rst;
    logic clear;

    int n_vec = 0;
    int n_err = 0;

    pts_sr_16_ctrl_if #(.NUM_WORDS(NW), .WORD_W(WW)) bus ();

    pts_sr_16_ctrl #(.NUM_WORDS(NW), .WORD_W(WW)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected word on the wire for a given stored word.
    function automatic logic [31:0] ew(input logic [31:0] w);
`ifdef PTS_BYTE_SWAP_EN
        return bswap32(w);
`else
        return w;
`endif
    endfunction

    // Block with word k at bits [32k+31:32k] equal to base + k*inc.
    function automatic logic [511:0] mk_blk(input logic [31:0] base, input logic [31:0] inc);
        logic [511:0] b;
        b = '0;
        for (int k = 0; k < 16; k++) b[32*k +: 32] = base + 32'(k) * inc;
        return b;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] blk;
        n_rst = 1'b0;
        clear = 1'b0;
        bus.load_valid  = 1'b0;
        bus.out_ready   = 1'b0;
        bus.parallel_in = '0;
        step();
        step();
        n_rst = 1'b1;
        step();

        // Reset then idle
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_ldrdy", 32'(bus.load_ready), 32'd1);
        check("rst_idx",   32'(bus.word_idx), 32'd0);
        check("rst_last",  32'(bus.out_last), 32'd0);
        check("rst_sout",  bus.serial_out, 32'd0);

        // Single block, words 0x0..0xF, emitted 0xF first
        bus.parallel_in = mk_blk(32'h0, 32'h1);
        bus.load_valid  = 1'b1;
        bus.out_ready   = 1'b1;
        check("t1_ldrdy", 32'(bus.load_ready), 32'd1);
        step();
        bus.load_valid = 1'b0;
        for (int j = 0; j < 16; j++) begin
            check("t1_valid", 32'(bus.out_valid), 32'd1);
            check("t1_sout",  bus.serial_out, ew(32'(15 - j)));
            check("t1_idx",   32'(bus.word_idx), 32'(j));
            check("t1_last",  32'(bus.out_last), (j == 15) ? 32'd1 : 32'd0);
            step();
        end
        check("t1_idle_valid", 32'(bus.out_valid), 32'd0);
        check("t1_idle_ldrdy", 32'(bus.load_ready), 32'd1);

        // Backpressure at word_idx 5 for 3 clks; a load attempt mid-block is ignored
        bus.parallel_in = mk_blk(32'h100, 32'h1);
        bus.load_valid  = 1'b1;
        step();
        bus.load_valid = 1'b0;
        for (int j = 0; j < 5; j++) begin
            check("t2_sout", bus.serial_out, ew(32'h100 + 32'(15 - j)));
            step();
        end
        bus.out_ready   = 1'b0;
        bus.load_valid  = 1'b1;
        bus.parallel_in = mk_blk(32'hEEEE0000, 32'h1);
        check("t2_ldrdy_busy", 32'(bus.load_ready), 32'd0);
        for (int s = 0; s < 3; s++) begin
            check("t2_stall_sout", bus.serial_out, ew(32'h10A));
            check("t2_stall_idx",  32'(bus.word_idx), 32'd5);
            check("t2_stall_last", 32'(bus.out_last), 32'd0);
            step();
        end
        bus.load_valid = 1'b0;
        bus.out_ready  = 1'b1;
        for (int j = 5; j < 16; j++) begin
            check("t2_sout", bus.serial_out, ew(32'h100 + 32'(15 - j)));
            check("t2_idx",  32'(bus.word_idx), 32'(j));
            step();
        end
        check("t2_idle_valid", 32'(bus.out_valid), 32'd0);

        // Back-to-back: block B loaded on A's last-word handshake
        bus.parallel_in = mk_blk(32'hA00, 32'h1);
        bus.load_valid  = 1'b1;
        step();
        bus.load_valid = 1'b0;
        for (int j = 0; j < 32; j++) begin
            if (j == 15) begin
                bus.load_valid  = 1'b1;
                bus.parallel_in = mk_blk(32'hBBBBBBBB, 32'h0);
                check("t3_ldrdy_last", 32'(bus.load_ready), 32'd1);
            end
            check("t3_valid", 32'(bus.out_valid), 32'd1);
            check("t3_sout",  bus.serial_out,
                  (j < 16) ? ew(32'hA00 + 32'(15 - j)) : ew(32'hBBBBBBBB));
            check("t3_idx",   32'(bus.word_idx), 32'(j % 16));
            step();
            if (j == 15) bus.load_valid = 1'b0;
        end
        check("t3_idle_valid", 32'(bus.out_valid), 32'd0);

        // Flush at word_idx 7, then reload starts from word 0
        bus.parallel_in = mk_blk(32'hC00, 32'h1);
        bus.load_valid  = 1'b1;
        step();
        bus.load_valid = 1'b0;
        for (int j = 0; j < 7; j++) step();
        check("t4_pre_idx", 32'(bus.word_idx), 32'd7);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("t4_valid", 32'(bus.out_valid), 32'd0);
        check("t4_ldrdy", 32'(bus.load_ready), 32'd1);
        check("t4_idx",   32'(bus.word_idx), 32'd0);
        bus.parallel_in = mk_blk(32'hD00, 32'h1);
        bus.load_valid  = 1'b1;
        step();
        bus.load_valid = 1'b0;
        check("t4_reload_idx",  32'(bus.word_idx), 32'd0);
        check("t4_reload_sout", bus.serial_out, ew(32'hD0F));
        for (int j = 0; j < 16; j++) step();
        check("t4_drain_valid", 32'(bus.out_valid), 32'd0);

        // Clear in the same cycle as a load drops the load
        clear = 1'b1;
        bus.load_valid = 1'b1;
        step();
        clear = 1'b0;
        bus.load_valid = 1'b0;
        check("t5_clr_ld_valid", 32'(bus.out_valid), 32'd0);

        // Byte order of a known top word
        blk = '0;
        blk[511:480] = 32'h11223344;
        bus.parallel_in = blk;
        bus.load_valid  = 1'b1;
        step();
        bus.load_valid = 1'b0;
`ifdef PTS_BYTE_SWAP_EN
        check("t6_swap", bus.serial_out, 32'h44332211);
`else
        check("t6_noswap", bus.serial_out, 32'h11223344);
`endif

        // Asynchronous reset mid-block
        step();
        #2;
        n_rst = 1'b0;
        #1;
        check("t7_rst_valid", 32'(bus.out_valid), 32'd0);
        check("t7_rst_idx",   32'(bus.word_idx), 32'd0);
        check("t7_rst_sout",  bus.serial_out, 32'd0);
        n_rst = 1'b1;
        step();
        check("t7_rst_ldrdy", 32'(bus.load_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
